// File: rtl/edge_det_pkg.sv
// Shared definitions for the edge_detect_debounce input conditioner:
// edge-mode encodings and the debounce counter width helper.
package edge_det_pkg;

    // Edge select encodings for the mode input
    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } mode_e;

    // Counter must hold values 0..n, so it needs clog2(n+1) bits (minimum 1)
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : edge_det_pkg

// File: rtl/edge_detect_debounce_chan.sv
// Single channel of the input conditioner: two-flop synchroniser, debounce
// counter and debounced level register. Exposes the next level and raw
// rise/fall strobes so the top can register pulses on the same edge the
// level changes.
module debounce_chan
    import edge_det_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic level_nxt_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned   CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q;
    logic          s2_q;
    logic          level_q;
    logic          level_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Accept a new level only after the synchronised input has differed
    // from it for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (s2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = s2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Synchroniser, counter and level state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            s1_q    <= d_i;
            s2_q    <= s1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o     = level_q;
    assign level_nxt_o = level_d;
    assign rise_o      = level_d & ~level_q;
    assign fall_o      = ~level_d & level_q;

endmodule : debounce_chan

// File: rtl/edge_detect_debounce.sv
// Multi-channel input conditioner: per-channel synchronise + debounce,
// mode-filtered one-cycle edge pulses and an "all channels high" pulse.
// Optional sticky event flags with per-channel clear are built when the
// macro EDGE_DET_STICKY_EN is defined; otherwise event_flag is 0 and
// irq is the OR of the pulse register.
module edge_detect_debounce
    import edge_det_pkg::*;
#(
    parameter int unsigned WIDTH           = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] D_in,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] clr,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] pulse,
    output logic             all_pulse,
    output logic [WIDTH-1:0] event_flag,
    output logic             irq
);

    logic [WIDTH-1:0] level_q;
    logic [WIDTH-1:0] level_nxt;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] pulse_q;
    logic [WIDTH-1:0] pulse_d;
    logic             all_pulse_q;
    logic             all_pulse_d;
    logic             rise_en;
    logic             fall_en;
    mode_e            mode_s;

    for (genvar g = 0; g < WIDTH; g++) begin : g_chan
        debounce_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .d_i        (D_in[g]),
            .level_o    (level_q[g]),
            .level_nxt_o(level_nxt[g]),
            .rise_o     (rise[g]),
            .fall_o     (fall[g])
        );
    end

    assign mode_s  = mode_e'(mode);
    assign rise_en = (mode_s == MODE_RISE) || (mode_s == MODE_BOTH);
    assign fall_en = (mode_s == MODE_FALL) || (mode_s == MODE_BOTH);

    // Mode filter on accepted transitions and 0->1 detect of the AND of all levels
    always_comb begin
        pulse_d     = (rise & {WIDTH{rise_en}}) | (fall & {WIDTH{fall_en}});
        all_pulse_d = (&level_nxt) & ~(&level_q);
    end

    // Registered pulses, high for exactly the cycle after the level change edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_q     <= '0;
            all_pulse_q <= 1'b0;
        end else begin
            pulse_q     <= pulse_d;
            all_pulse_q <= all_pulse_d;
        end
    end

    assign level     = level_q;
    assign pulse     = pulse_q;
    assign all_pulse = all_pulse_q;

`ifdef EDGE_DET_STICKY_EN
    logic [WIDTH-1:0] event_flag_q;
    logic [WIDTH-1:0] event_flag_d;
    logic             irq_q;

    // A pulse in the same cycle as its clear keeps the flag set
    always_comb begin
        event_flag_d = (event_flag_q & ~clr) | pulse_q;
    end

    // Sticky flags and interrupt request track each other on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            event_flag_q <= '0;
            irq_q        <= 1'b0;
        end else begin
            event_flag_q <= event_flag_d;
            irq_q        <= |event_flag_d;
        end
    end

    assign event_flag = event_flag_q;
    assign irq        = irq_q;
`else
    logic unused_clr;

    assign unused_clr = ^clr;
    assign event_flag = '0;
    assign irq        = |pulse_q;
`endif

endmodule : edge_detect_debounce

// File: tb/tb_edge_detect_debounce.sv
// Directed self-checking bench for edge_detect_debounce (WIDTH=16,
// DEBOUNCE_CYCLES=4). Inputs change 1 ns after a rising edge; outputs are
// checked 1 ns after a rising edge.
module tb_edge_detect_debounce;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] D_in;
    logic [1:0]  mode;
    logic [15:0] clr;
    logic [15:0] level;
    logic [15:0] pulse;
    logic        all_pulse;
    logic [15:0] event_flag;
    logic        irq;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    edge_detect_debounce #(
        .WIDTH          (16),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .D_in      (D_in),
        .mode      (mode),
        .clr       (clr),
        .level     (level),
        .pulse     (pulse),
        .all_pulse (all_pulse),
        .event_flag(event_flag),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_flags();
        clr = '1;
        tick(1);
        clr = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        D_in  = '0;
        mode  = 2'b01;
        clr   = '0;
        tick(3);
        n_chk++; if (level !== 16'h0000) $display("FAIL reset_level got=%h exp=%h", level, 16'h0000); else n_pass++;
        n_chk++; if (pulse !== 16'h0000) $display("FAIL reset_pulse got=%h exp=%h", pulse, 16'h0000); else n_pass++;
        n_chk++; if (all_pulse !== 1'b0) $display("FAIL reset_all_pulse got=%b exp=0", all_pulse); else n_pass++;
        n_chk++; if (event_flag !== 16'h0000) $display("FAIL reset_event_flag got=%h exp=%h", event_flag, 16'h0000); else n_pass++;
        n_chk++; if (irq !== 1'b0) $display("FAIL reset_irq got=%b exp=0", irq); else n_pass++;
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_rise();
        mode    = 2'b01;
        D_in[3] = 1'b1;
        tick(5);  // through edge 4
        n_chk++; if (level !== 16'h0000) $display("FAIL rise_level_early got=%h exp=%h", level, 16'h0000); else n_pass++;
        n_chk++; if (pulse !== 16'h0000) $display("FAIL rise_pulse_early got=%h exp=%h", pulse, 16'h0000); else n_pass++;
        tick(1);  // edge 5
        n_chk++; if (level !== 16'h0008) $display("FAIL rise_level got=%h exp=%h", level, 16'h0008); else n_pass++;
        n_chk++; if (pulse !== 16'h0008) $display("FAIL rise_pulse got=%h exp=%h", pulse, 16'h0008); else n_pass++;
`ifndef EDGE_DET_STICKY_EN
        n_chk++; if (irq !== 1'b1) $display("FAIL rise_irq got=%b exp=1", irq); else n_pass++;
`endif
        tick(1);  // edge 6
        n_chk++; if (pulse !== 16'h0000) $display("FAIL rise_pulse_end got=%h exp=%h", pulse, 16'h0000); else n_pass++;
        n_chk++; if (level !== 16'h0008) $display("FAIL rise_level_hold got=%h exp=%h", level, 16'h0008); else n_pass++;
        D_in[3] = 1'b0;
        tick(6);
        n_chk++; if (level !== 16'h0000) $display("FAIL rise_fall_level got=%h exp=%h", level, 16'h0000); else n_pass++;
        n_chk++; if (pulse !== 16'h0000) $display("FAIL rise_fall_suppressed got=%h exp=%h", pulse, 16'h0000); else n_pass++;
        tick(2);
        clear_flags();
    endtask

    task automatic test_glitch();
        mode    = 2'b11;
        D_in[0] = 1'b1;
        tick(3);
        D_in[0] = 1'b0;
        for (int unsigned k = 0; k < 10; k++) begin
            n_chk++; if ({level[0], pulse[0]} !== 2'b00) $display("FAIL glitch_k%0d level0=%b pulse0=%b exp=0,0", k, level[0], pulse[0]); else n_pass++;
            tick(1);
        end
        clear_flags();
    endtask

    task automatic test_modes();
        mode    = 2'b10;
        D_in[5] = 1'b1;
        tick(6);
        n_chk++; if (level !== 16'h0020) $display("FAIL fallmode_level got=%h exp=%h", level, 16'h0020); else n_pass++;
        n_chk++; if (pulse !== 16'h0000) $display("FAIL fallmode_rise_suppressed got=%h exp=%h", pulse, 16'h0000); else n_pass++;
        tick(2);
        D_in[5] = 1'b0;
        tick(6);
        n_chk++; if (pulse !== 16'h0020) $display("FAIL fallmode_pulse got=%h exp=%h", pulse, 16'h0020); else n_pass++;
        n_chk++; if (level !== 16'h0000) $display("FAIL fallmode_level_low got=%h exp=%h", level, 16'h0000); else n_pass++;
        tick(2);
        mode    = 2'b11;
        D_in[5] = 1'b1;
        tick(6);
        n_chk++; if (pulse !== 16'h0020) $display("FAIL bothmode_rise got=%h exp=%h", pulse, 16'h0020); else n_pass++;
        tick(2);
        D_in[5] = 1'b0;
        tick(6);
        n_chk++; if (pulse !== 16'h0020) $display("FAIL bothmode_fall got=%h exp=%h", pulse, 16'h0020); else n_pass++;
        tick(2);
        mode    = 2'b00;
        D_in[5] = 1'b1;
        tick(6);
        n_chk++; if (level !== 16'h0020) $display("FAIL offmode_level got=%h exp=%h", level, 16'h0020); else n_pass++;
        n_chk++; if (pulse !== 16'h0000) $display("FAIL offmode_rise got=%h exp=%h", pulse, 16'h0000); else n_pass++;
        tick(2);
        D_in[5] = 1'b0;
        tick(6);
        n_chk++; if (level !== 16'h0000) $display("FAIL offmode_level_low got=%h exp=%h", level, 16'h0000); else n_pass++;
        n_chk++; if (pulse !== 16'h0000) $display("FAIL offmode_fall got=%h exp=%h", pulse, 16'h0000); else n_pass++;
        tick(2);
        clear_flags();
    endtask

    task automatic test_all_pulse();
        mode = 2'b01;
        D_in = 16'h7FFF;
        tick(6);
        n_chk++; if (level !== 16'h7FFF) $display("FAIL all_pre_level got=%h exp=%h", level, 16'h7FFF); else n_pass++;
        n_chk++; if (all_pulse !== 1'b0) $display("FAIL all_pre got=%b exp=0", all_pulse); else n_pass++;
        tick(2);
        D_in = 16'hFFFF;
        tick(6);
        n_chk++; if (all_pulse !== 1'b1) $display("FAIL all_first got=%b exp=1", all_pulse); else n_pass++;
        n_chk++; if (pulse !== 16'h8000) $display("FAIL all_first_pulse got=%h exp=%h", pulse, 16'h8000); else n_pass++;
        tick(1);
        n_chk++; if (all_pulse !== 1'b0) $display("FAIL all_first_end got=%b exp=0", all_pulse); else n_pass++;
        tick(1);
        D_in = 16'hFFEF;
        tick(6);
        n_chk++; if (level !== 16'hFFEF) $display("FAIL all_drop_level got=%h exp=%h", level, 16'hFFEF); else n_pass++;
        n_chk++; if (all_pulse !== 1'b0) $display("FAIL all_drop got=%b exp=0", all_pulse); else n_pass++;
        tick(2);
        D_in = 16'hFFFF;
        tick(6);
        n_chk++; if (all_pulse !== 1'b1) $display("FAIL all_second got=%b exp=1", all_pulse); else n_pass++;
        n_chk++; if (pulse !== 16'h0010) $display("FAIL all_second_pulse got=%h exp=%h", pulse, 16'h0010); else n_pass++;
        tick(1);
        n_chk++; if (all_pulse !== 1'b0) $display("FAIL all_second_end got=%b exp=0", all_pulse); else n_pass++;
        D_in = '0;
        tick(8);
        clear_flags();
    endtask

    task automatic test_sticky();
        mode = 2'b11;
        clear_flags();
        D_in[2] = 1'b1;
        tick(6);
        n_chk++; if (pulse !== 16'h0004) $display("FAIL sticky_pulse1 got=%h exp=%h", pulse, 16'h0004); else n_pass++;
`ifdef EDGE_DET_STICKY_EN
        tick(1);
        n_chk++; if (event_flag !== 16'h0004) $display("FAIL sticky_set got=%h exp=%h", event_flag, 16'h0004); else n_pass++;
        n_chk++; if (irq !== 1'b1) $display("FAIL sticky_irq got=%b exp=1", irq); else n_pass++;
        tick(1);
        D_in[2] = 1'b0;
        tick(6);
        n_chk++; if (pulse !== 16'h0004) $display("FAIL sticky_pulse2 got=%h exp=%h", pulse, 16'h0004); else n_pass++;
        clr[2] = 1'b1;
        tick(1);
        clr[2] = 1'b0;
        n_chk++; if (event_flag !== 16'h0004) $display("FAIL sticky_set_wins got=%h exp=%h", event_flag, 16'h0004); else n_pass++;
        n_chk++; if (irq !== 1'b1) $display("FAIL sticky_set_wins_irq got=%b exp=1", irq); else n_pass++;
        tick(1);
        n_chk++; if (event_flag !== 16'h0004) $display("FAIL sticky_hold got=%h exp=%h", event_flag, 16'h0004); else n_pass++;
        clr[2] = 1'b1;
        tick(1);
        clr[2] = 1'b0;
        n_chk++; if (event_flag !== 16'h0000) $display("FAIL sticky_clear got=%h exp=%h", event_flag, 16'h0000); else n_pass++;
        n_chk++; if (irq !== 1'b0) $display("FAIL sticky_clear_irq got=%b exp=0", irq); else n_pass++;
`else
        n_chk++; if (irq !== 1'b1) $display("FAIL nosticky_irq got=%b exp=1", irq); else n_pass++;
        n_chk++; if (event_flag !== 16'h0000) $display("FAIL nosticky_flag got=%h exp=%h", event_flag, 16'h0000); else n_pass++;
        clr = '1;
        tick(1);
        clr = '0;
        n_chk++; if (irq !== 1'b0) $display("FAIL nosticky_irq_end got=%b exp=0", irq); else n_pass++;
        D_in[2] = 1'b0;
        tick(6);
`endif
        tick(2);
        clear_flags();
    endtask

    task automatic test_reset_midcount();
        mode    = 2'b01;
        D_in[9] = 1'b1;
        tick(8);
        n_chk++; if (level !== 16'h0200) $display("FAIL rmc_pre_level got=%h exp=%h", level, 16'h0200); else n_pass++;
        D_in[7] = 1'b1;
        tick(4);  // channel 7 counter now at 2
        rst_n = 1'b0;
        #1;
        n_chk++; if (level !== 16'h0000) $display("FAIL rmc_level got=%h exp=%h", level, 16'h0000); else n_pass++;
        n_chk++; if (pulse !== 16'h0000) $display("FAIL rmc_pulse got=%h exp=%h", pulse, 16'h0000); else n_pass++;
        n_chk++; if (event_flag !== 16'h0000) $display("FAIL rmc_flag got=%h exp=%h", event_flag, 16'h0000); else n_pass++;
        n_chk++; if (irq !== 1'b0) $display("FAIL rmc_irq got=%b exp=0", irq); else n_pass++;
        tick(2);
        rst_n = 1'b1;
        tick(5);  // edges 0..4 after release
        n_chk++; if (level !== 16'h0000) $display("FAIL rmc_level_early got=%h exp=%h", level, 16'h0000); else n_pass++;
        n_chk++; if (pulse !== 16'h0000) $display("FAIL rmc_pulse_early got=%h exp=%h", pulse, 16'h0000); else n_pass++;
        tick(1);  // edge 5
        n_chk++; if (level !== 16'h0280) $display("FAIL rmc_level_after got=%h exp=%h", level, 16'h0280); else n_pass++;
        n_chk++; if (pulse !== 16'h0280) $display("FAIL rmc_pulse_after got=%h exp=%h", pulse, 16'h0280); else n_pass++;
        tick(1);
        n_chk++; if (pulse !== 16'h0000) $display("FAIL rmc_pulse_end got=%h exp=%h", pulse, 16'h0000); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_rise();
        test_glitch();
        test_modes();
        test_all_pulse();
        test_sticky();
        test_reset_midcount();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_edge_detect_debounce
